// File: rtl/pulse_stretch.sv
// pulse_stretch: turns a short internal event into an output pulse that stays high for at
// least HOLD_TICKS ticks, followed by at least GAP_TICKS ticks low. One tick is TICK_DIV clk
// cycles. Events that arrive while a pulse is in progress are queued one deep, or counted as
// dropped once the queue slot is taken.
//
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   trigIn       - event request; each rising edge is one event
//   clearDrops   - synchronous clear of dropCount; wins over a same-cycle increment
//   stretchedOut - stretched pulse output, registered
//   busy         - a pulse or gap is in progress, or an event is queued
//   dropCount    - saturating count of discarded events
module pulse_stretch #(
    parameter int unsigned HOLD_TICKS = 8,
    parameter int unsigned GAP_TICKS  = 2,
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned RETRIG     = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigIn,
    input  logic       clearDrops,
    output logic       stretchedOut,
    output logic       busy,
    output logic [7:0] dropCount
);

    localparam int unsigned TickMax = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;
    localparam int unsigned PreW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_t;

    state_t            r_state;
    logic              r_trig_s;
    logic              r_trig_prev;
    logic              r_pending;
    logic              r_out;
    logic [PreW-1:0]   r_pre;
    logic [TickW-1:0]  r_tick;
    logic [7:0]        r_drop;

    logic              w_event;
    logic              w_pre_wrap;
    logic              w_hold_done;
    logic              w_gap_done;
    logic              w_drop_inc;

    // trigIn is registered once before edge detection, so the output rises one clk edge after
    // the edge that sampled trigIn high.
    assign w_event     = r_trig_s & ~r_trig_prev;
    assign w_pre_wrap  = (r_pre == PreW'(TICK_DIV - 1));
    assign w_hold_done = w_pre_wrap && (r_tick == TickW'(HOLD_TICKS - 1));
    assign w_gap_done  = w_pre_wrap && (r_tick == TickW'(GAP_TICKS - 1));

    // An event is dropped only when the single queue slot is already occupied. In the gap
    // expiry cycle a queued event is consumed, so a new event takes its place instead.
    always_comb begin
        w_drop_inc = 1'b0;
        case (r_state)
            StHold:  w_drop_inc = (RETRIG == 0) && w_event && r_pending;
            StGap:   w_drop_inc = !w_gap_done && w_event && r_pending;
            default: w_drop_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_trig_s    <= 1'b1;
            r_trig_prev <= 1'b1;
            r_pending   <= 1'b0;
            r_out       <= 1'b0;
            r_pre       <= '0;
            r_tick      <= '0;
            r_drop      <= 8'd0;
        end else begin
            r_trig_s    <= trigIn;
            r_trig_prev <= r_trig_s;

            if (clearDrops) begin
                r_drop <= 8'd0;
            end else if (w_drop_inc && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end

            // Free-running tick timebase; every state transition below reloads it.
            if (w_pre_wrap) begin
                r_pre  <= '0;
                r_tick <= r_tick + 1'b1;
            end else begin
                r_pre  <= r_pre + 1'b1;
            end

            case (r_state)
                StIdle: begin
                    r_pre  <= '0;
                    r_tick <= '0;
                    if (w_event || r_pending) begin
                        r_state   <= StHold;
                        r_out     <= 1'b1;
                        r_pending <= 1'b0;
                    end
                end
                StHold: begin
                    if ((RETRIG != 0) && w_event) begin
                        // Retrigger beats expiry: restart the hold with the output still high.
                        r_pre  <= '0;
                        r_tick <= '0;
                    end else begin
                        if (w_event && !r_pending) begin
                            r_pending <= 1'b1;
                        end
                        if (w_hold_done) begin
                            r_state <= StGap;
                            r_out   <= 1'b0;
                            r_pre   <= '0;
                            r_tick  <= '0;
                        end
                    end
                end
                StGap: begin
                    if (w_gap_done) begin
                        r_pre  <= '0;
                        r_tick <= '0;
                        if (r_pending || w_event) begin
                            // Straight back to hold keeps the low time at exactly one gap.
                            r_state   <= StHold;
                            r_out     <= 1'b1;
                            r_pending <= r_pending & w_event;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else if (w_event && !r_pending) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign stretchedOut = r_out;
    assign busy         = (r_state != StIdle) | r_pending;
    assign dropCount    = r_drop;

endmodule
